alu_issue_queue: RTL and testbench

Operand-queue and result-register stage sitting directly upstream and downstream of the combinational 32-bit ALU. It accepts `{A, B, ALUOp}` commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the head entry to the ALU from registered storage, then captures the ALU result `C` into an output register with its own valid/ready handshake. Throughput is one command per cycle; a stalled consumer back-pressures the producer.

---
 rtl/alu_issue_queue.sv | 128 ++++++++++++
 tb/tb_alu_issue_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// ALU operand queue (DEPTH-entry FIFO) plus registered result stage. Results appear 2 cycles after acceptance, 1/cycle.
// Backpressure: out_ready low stalls issue; the FIFO fills and in_ready drops when count reaches DEPTH.

// Generic FIFO with a registered head entry; pop/push may coincide.
// No internal overflow/underflow guard: the caller qualifies push_vld/pop_vld.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     core_clk,
  input  logic                     arst_n,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; the owner masks the head while empty.
  always_ff @(posedge core_clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !pop_vld)
        count <= count + 1'b1;
      else if (!push_vld && pop_vld)
        count <= count - 1'b1;
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Queue + result register around an external combinational ALU.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [2:0]             in_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_op,
  input  logic [31:0]            alu_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_c,
  output logic [2:0]             out_op,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            done_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } cmd_t;

  cmd_t in_cmd;
  cmd_t head_cmd;
  logic empty;
  logic push;
  logic issue;
  logic handshake;

  assign in_cmd = '{a: in_a, b: in_b, op: in_op};

  fifo #(
    .W    ($bits(cmd_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .core_clk(clk),
    .arst_n  (reset),
    .push_vld(push),
    .push_dat(in_cmd),
    .pop_vld (issue),
    .head_dat(head_cmd),
    .count   (count)
  );

  // No full bypass: a pop in the same cycle does not open a slot.
  assign empty     = (count == '0);
  assign in_ready  = (count != CW'(DEPTH)) && reset;
  assign push      = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign issue     = !empty && (!out_valid || out_ready);

  assign alu_a  = empty ? '0 : head_cmd.a;
  assign alu_b  = empty ? '0 : head_cmd.b;
  assign alu_op = empty ? '0 : head_cmd.op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_op    <= '0;
      done_cnt  <= '0;
    end else begin
      // Issue overrides the drain so a handshake plus issue leaves no bubble.
      if (issue) begin
        out_c     <= alu_c;
        out_op    <= alu_op;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake) done_cnt <= done_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed vectors, expected results queued at acceptance and checked by a monitor.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_a;
  logic [31:0]            in_b;
  logic [2:0]             in_op;
  logic [31:0]            alu_a;
  logic [31:0]            alu_b;
  logic [2:0]             alu_op;
  logic [31:0]            alu_c;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_c;
  logic [2:0]             out_op;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            done_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] c;
    logic [2:0]  op;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t sb[$];
  chk_t cq[$];

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_c    (alu_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c),
    .out_op   (out_op),
    .count    (count),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    alu_c = '0;
    case (alu_op)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a >> alu_b;
      default: alu_c = $unsigned($signed(alu_a) >>> alu_b);
    endcase
  end

  // Monitor: drains queued state checks, then scores any output handshake.
  initial begin
    chk_t c;
    exp_t e;
    forever begin
      @(negedge clk);
      while (cq.size() > 0) begin
        c = cq.pop_front();
        checks++;
        if (c.act !== c.exp) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", c.name, c.act, c.exp);
        end
      end
      if (reset && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result actual=%h op=%0d expected=none", out_c, out_op);
        end else begin
          e = sb.pop_front();
          if (out_c !== e.c || out_op !== e.op) begin
            failures++;
            $display("FAIL result actual=%h op=%0d expected=%h op=%0d", out_c, out_op, e.c, e.op);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cq.push_back('{name: name, act: act, exp: exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command; returns 1 ns after the accepting edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] c);
    bit acc;
    acc      = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{c: c, op: op});
        acc = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_out_c", out_c, 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single add: latency and head drive
    out_ready = 1'b1;
    push(32'd5, 32'd3, 3'b000, 32'd8);
    chk("head_alu_a", alu_a, 32'd5);
    chk("head_alu_b", alu_b, 32'd3);
    chk("lat_no_early_valid", 32'(out_valid), 32'd0);
    chk("lat_count1", 32'(count), 32'd1);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_out_c", out_c, 32'd8);
    chk("lat_count0", 32'(count), 32'd0);
    step();
    chk("done_1", 32'(done_cnt), 32'd1);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream
    push(32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE);
    push(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000);
    push(32'h8000_0000, 32'd4, 3'b100, 32'h0800_0000);
    push(32'h8000_0000, 32'd4, 3'b101, 32'hF800_0000);
    chk("stream_valid_a", 32'(out_valid), 32'd1);
    chk("stream_srl", out_c, 32'h0800_0000);
    step();
    chk("stream_valid_b", 32'(out_valid), 32'd1);
    chk("stream_sra", out_c, 32'hF800_0000);
    step();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("done_5", 32'(done_cnt), 32'd5);

    // Fill under backpressure, then full + handshake + issue
    out_ready = 1'b0;
    push(32'h0000_00F0, 32'h0000_000F, 3'b011, 32'h0000_00FF);
    push(32'd1, 32'd2, 3'b000, 32'd3);
    push(32'd10, 32'd1, 3'b001, 32'd9);
    push(32'hFFFF_0000, 32'h1234_5678, 3'b010, 32'h1234_0000);
    push(32'h0000_00F0, 32'd4, 3'b100, 32'h0000_000F);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    in_a     = 32'h8000_0000;
    in_b     = 32'd40;
    in_op    = 3'b111;
    in_valid = 1'b1;
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_in_ready", 32'(in_ready), 32'd0);
    chk("full_hold_out_c", out_c, 32'h0000_00FF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_no_bypass", 32'(in_ready), 32'd0);
    step();
    chk("after_full_count", 32'(count), 32'd3);
    chk("after_full_in_ready", 32'(in_ready), 32'd1);
    chk("after_full_out_c", out_c, 32'd3);
    @(negedge clk);
    chk("retry_accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back('{c: 32'hFFFF_FFFF, op: 3'b111});
    step();
    in_valid = 1'b0;
    chk("push_issue_count", 32'(count), 32'd3);
    chk("drain_valid_0", 32'(out_valid), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    step();
    chk("drain_end_valid", 32'(out_valid), 32'd0);
    chk("drain_end_count", 32'(count), 32'd0);
    chk("done_11", 32'(done_cnt), 32'd11);

    // Reset mid-operation discards everything
    out_ready = 1'b0;
    push(32'd1, 32'd1, 3'b000, 32'd2);
    push(32'd2, 32'd2, 3'b000, 32'd4);
    push(32'd3, 32'd3, 3'b000, 32'd6);
    push(32'd4, 32'd4, 3'b000, 32'd8);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd3);
    sb.delete();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_c", out_c, 32'd0);
    step();
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    chk("no_stale_valid", 32'(out_valid), 32'd0);
    chk("no_stale_count", 32'(count), 32'd0);
    push(32'd7, 32'd2, 3'b100, 32'd1);
    repeat (2) step();
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    // done_cnt wrap
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 65535; i++) push(32'(i), 32'd1, 3'b000, 32'(i) + 32'd1);
    repeat (3) step();
    chk("done_ffff", 32'(done_cnt), 32'h0000_FFFF);
    push(32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0);
    repeat (3) step();
    chk("done_wrap", 32'(done_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
